// File: rtl/lcd_pkg.sv
// Shared types and constants for the Spartan-3E character LCD writer.
// Delays are in microseconds; users scale by CLK_MHZ.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, CFG, SET_ADDR, WRITE_CHAR, NEXT, DONE
  } lcd_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SETUP, TX_EHI, TX_HOLD, TX_POST
  } tx_phase_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [15:0] PWR_US   = 16'd15000;
  localparam logic [15:0] INIT1_US = 16'd4100;
  localparam logic [15:0] INIT2_US = 16'd100;
  localparam logic [15:0] CMD_US   = 16'd40;
  localparam logic [15:0] NIB_US   = 16'd1;
  localparam logic [15:0] CLEAR_US = 16'd1640;

  function automatic logic [3:0] pick_nib(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One 4-bit LCD transfer: 2-cycle setup, E_CYCLES enable pulse, 1-cycle hold,
// then a caller-supplied post-wait. A new start is accepted in the done cycle.
module lcd_nibble_tx import lcd_pkg::*; #(
  parameter int E_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  nibble,
  input  logic        rs,
  input  logic [23:0] wait_cycles,
  output logic        done,
  output logic        lcd_e,
  output logic [3:0]  lcd_d,
  output logic        lcd_rs
);

  tx_phase_e   ph, ph_n;
  logic [23:0] cnt, cnt_n, wait_q;
  logic        load;

  assign done = (ph == TX_POST) && (cnt == 24'd0);
  assign load = start && ((ph == TX_IDLE) || done);

  always_comb begin
    ph_n  = ph;
    cnt_n = cnt;
    if (load) begin
      ph_n  = TX_SETUP;
      cnt_n = 24'd1;
    end else begin
      case (ph)
        TX_SETUP: if (cnt == 24'd0) begin
                    ph_n  = TX_EHI;
                    cnt_n = 24'(E_CYCLES - 1);
                  end else cnt_n = cnt - 24'd1;
        TX_EHI:   if (cnt == 24'd0) ph_n = TX_HOLD;
                  else cnt_n = cnt - 24'd1;
        TX_HOLD:  begin
                    ph_n  = TX_POST;
                    cnt_n = wait_q - 24'd1;
                  end
        TX_POST:  if (cnt == 24'd0) ph_n = TX_IDLE;
                  else cnt_n = cnt - 24'd1;
        default:  ph_n = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= TX_IDLE;
      cnt    <= '0;
      wait_q <= '0;
      lcd_e  <= 1'b0;
      lcd_d  <= '0;
      lcd_rs <= 1'b0;
    end else begin
      ph    <= ph_n;
      cnt   <= cnt_n;
      lcd_e <= (ph_n == TX_EHI);
      // data/rs only move on load, which is always with E low
      if (load) begin
        lcd_d  <= nibble;
        lcd_rs <= rs;
        wait_q <= wait_cycles;
      end
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit init, configuration and 32-character frame writer.
// Define LCD_REFRESH_EN to rewrite the frame every REFRESH_US; otherwise DONE is terminal.
module lcd_char_writer import lcd_pkg::*; #(
  parameter int CLK_MHZ    = 50,
  parameter int E_CYCLES   = 12,
  parameter int REFRESH_US = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       sf_ce0,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [23:0] PWR_CYC = 24'(PWR_US * CLK_MHZ);
  localparam logic [23:0] REF_CYC = 24'(REFRESH_US * CLK_MHZ);

  lcd_state_e  st, st_n;
  logic [2:0]  step, step_n;
  logic [23:0] dly, wait_cyc;
  logic [15:0] wait_us;
  logic [4:0]  idx;
  logic        last, go, tx_done, nib_rs;
  logic [7:0]  byte_q, cfg_byte, addr_cmd;
  logic [3:0]  nib;

  assign char_addr = idx;
  assign lcd_rw    = 1'b0;
  assign sf_ce0    = 1'b1;
  assign addr_cmd  = (idx == 5'd16) ? CMD_LINE2 : CMD_LINE1;
  assign wait_cyc  = 24'(wait_us * CLK_MHZ);

  // The next transfer is launched in the same cycle the current one finishes,
  // so its parameters are decoded from the next state/step.
  always_comb begin
    st_n   = st;
    step_n = step;
    go     = 1'b0;
    case (st)
      PWR_WAIT:   if (dly == PWR_CYC - 24'd1) begin st_n = INIT; step_n = '0; go = 1'b1; end
      INIT:       if (tx_done) begin
                    go = 1'b1;
                    if (step == 3'd3) begin st_n = CFG; step_n = '0; end
                    else step_n = step + 3'd1;
                  end
      CFG:        if (tx_done) begin
                    go = 1'b1;
                    if (step == 3'd7) begin st_n = SET_ADDR; step_n = '0; end
                    else step_n = step + 3'd1;
                  end
      SET_ADDR:   if (tx_done) begin
                    go = 1'b1;
                    if (step[0]) begin st_n = WRITE_CHAR; step_n = '0; end
                    else step_n = 3'd1;
                  end
      WRITE_CHAR: if (tx_done) begin st_n = NEXT; go = 1'b1; end
      NEXT:       if (tx_done) begin
                    if (last) st_n = DONE;
                    else begin
                      go = 1'b1;
                      if (idx == 5'd16) begin st_n = SET_ADDR; step_n = '0; end
                      else st_n = WRITE_CHAR;
                    end
                  end
`ifdef LCD_REFRESH_EN
      DONE:       if (dly == REF_CYC - 24'd1) begin st_n = SET_ADDR; step_n = '0; go = 1'b1; end
`else
      DONE:       ;
`endif
      default:    st_n = PWR_WAIT;
    endcase

    case (step_n[2:1])
      2'd0:    cfg_byte = CMD_FUNC_SET;
      2'd1:    cfg_byte = CMD_ENTRY;
      2'd2:    cfg_byte = CMD_DISP_ON;
      default: cfg_byte = CMD_CLEAR;
    endcase

    nib     = 4'h0;
    nib_rs  = 1'b0;
    wait_us = '0;
    case (st_n)
      INIT:       begin
                    nib = (step_n == 3'd3) ? 4'h2 : 4'h3;
                    case (step_n)
                      3'd0:    wait_us = INIT1_US;
                      3'd1:    wait_us = INIT2_US;
                      default: wait_us = CMD_US;
                    endcase
                  end
      CFG:        begin
                    nib     = pick_nib(cfg_byte, step_n[0]);
                    wait_us = !step_n[0] ? NIB_US : ((step_n == 3'd7) ? CLEAR_US : CMD_US);
                  end
      SET_ADDR:   begin
                    nib     = pick_nib(addr_cmd, step_n[0]);
                    wait_us = step_n[0] ? CMD_US : NIB_US;
                  end
      WRITE_CHAR: begin nib = char_data[7:4]; nib_rs = 1'b1; wait_us = NIB_US; end
      NEXT:       begin nib = byte_q[3:0];    nib_rs = 1'b1; wait_us = CMD_US; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= PWR_WAIT;
      step       <= '0;
      dly        <= '0;
      idx        <= '0;
      last       <= 1'b0;
      byte_q     <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st   <= st_n;
      step <= step_n;
      if (st_n != st) dly <= '0;
      else if (st == PWR_WAIT || (st == DONE && dly != REF_CYC - 24'd1)) dly <= dly + 24'd1;
      if (go && st_n == WRITE_CHAR) byte_q <= char_data;
      // address advances as the low nibble launches, well before the next sample
      if (st == WRITE_CHAR && st_n == NEXT) begin
        last <= (idx == 5'd31);
        if (idx != 5'd31) idx <= idx + 5'd1;
      end
      if (st == DONE && st_n == SET_ADDR) begin
        idx  <= '0;
        last <= 1'b0;
      end
      if (st == CFG && st_n == SET_ADDR) init_done <= 1'b1;
      frame_done <= (st == NEXT) && (st_n == DONE);
    end
  end

  lcd_nibble_tx #(.E_CYCLES(E_CYCLES)) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (go),
    .nibble      (nib),
    .rs          (nib_rs),
    .wait_cycles (wait_cyc),
    .done        (tx_done),
    .lcd_e       (lcd_e),
    .lcd_d       (lcd_d),
    .lcd_rs      (lcd_rs)
  );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench: decodes the LCD strobe stream and compares it with a nibble list built
// from the HD44780 sequence rules; also checks strobe timing and mid-write reset.
module tb_lcd_char_writer;

  localparam int CLK = 1;
  localparam int E   = 12;
  localparam int R   = 3000;
  localparam int P   = 15000 * CLK;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic [3:0] lcd_d;
  logic       lcd_e, lcd_rs, lcd_rw, sf_ce0, init_done, frame_done;

  logic [7:0] mem [32];
  assign char_data = mem[char_addr];

  always #5 clk = ~clk;

  lcd_char_writer #(.CLK_MHZ(CLK), .E_CYCLES(E), .REFRESH_US(R)) dut (
    .clk(clk), .rst_n(rst_n), .char_addr(char_addr), .char_data(char_data),
    .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .sf_ce0(sf_ce0), .init_done(init_done), .frame_done(frame_done)
  );

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         t;     // rise cycle (observed) or gap to next rise (expected)
    int         addr;
    logic       idn;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  nchk = 0, nfail = 0;
  int  cyc = 0, base = 0, rise_cyc = 0, fall_cyc = -100, chg_cyc = -100;
  int  fd_cnt = 0, fd_cyc = 0;
  logic       e_prev = 1'b0;
  logic [4:0] drs_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_nib(input logic rs, input logic [3:0] n, input int wus, input int addr, input logic idn);
    ev_t e;
    e.rs = rs; e.nib = n; e.t = 3 + E + wus * CLK; e.addr = addr; e.idn = idn;
    exp_q.push_back(e);
  endtask

  task automatic add_byte(input logic rs, input logic [7:0] b, input int lw, input int addr, input logic idn);
    add_nib(rs, b[7:4], 1, addr, idn);
    add_nib(rs, b[3:0], lw, -1, idn);
  endtask

  task automatic build_exp();
    exp_q.delete();
    add_nib(1'b0, 4'h3, 4100, -1, 1'b0);
    add_nib(1'b0, 4'h3, 100, -1, 1'b0);
    add_nib(1'b0, 4'h3, 40, -1, 1'b0);
    add_nib(1'b0, 4'h2, 40, -1, 1'b0);
    add_byte(1'b0, 8'h28, 40, -1, 1'b0);
    add_byte(1'b0, 8'h06, 40, -1, 1'b0);
    add_byte(1'b0, 8'h0C, 40, -1, 1'b0);
    add_byte(1'b0, 8'h01, 1640, -1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 0)  add_byte(1'b0, 8'h80, 40, -1, 1'b1);
      if (i == 16) add_byte(1'b0, 8'hC0, 40, -1, 1'b1);
      add_byte(1'b1, mem[i], 40, i, 1'b1);
    end
  endtask

  // strobe monitor: records every E rise and checks width / setup / hold
  always @(posedge clk) begin : mon
    ev_t o;
    #1;
    cyc++;
    if (!rst_n) begin
      fall_cyc = cyc - 10;
      chg_cyc  = cyc - 10;
    end else begin
      if (lcd_e && !e_prev) begin
        o.rs = lcd_rs; o.nib = lcd_d; o.t = cyc; o.addr = int'(char_addr); o.idn = init_done;
        obs_q.push_back(o);
        rise_cyc = cyc;
        chk("setup", cyc - chg_cyc >= 2, 1);
      end
      if (!lcd_e && e_prev) begin
        chk("e_width", cyc - rise_cyc, E);
        fall_cyc = cyc;
      end
      if ({lcd_rs, lcd_d} != drs_prev) begin
        chk("hold", !lcd_e && (cyc - fall_cyc >= 2), 1);
        chg_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    e_prev   = lcd_e;
    drs_prev = {lcd_rs, lcd_d};
  end

  task automatic release_rst();
    @(negedge clk);
    obs_q.delete();
    fd_cnt = 0;
    base   = cyc;
    rst_n  = 1'b1;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 30000 && fd_cnt == 0; i++) @(posedge clk);
    repeat (50) @(posedge clk);
    #2;
  endtask

  task automatic verify_frame();
    int n;
    build_exp();
    n = obs_q.size();
    chk("n_nibbles", n, exp_q.size());
    if (n > 0) chk("first_rise", obs_q[0].t - base, P + 2);
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      chk("nibble", {obs_q[k].rs, obs_q[k].nib}, {exp_q[k].rs, exp_q[k].nib});
      chk("init_done", obs_q[k].idn, exp_q[k].idn);
      if (exp_q[k].addr >= 0) chk("char_addr", obs_q[k].addr, exp_q[k].addr);
      if (k + 1 < n && k + 1 < exp_q.size()) chk("gap", obs_q[k+1].t - obs_q[k].t, exp_q[k].t);
    end
    chk("frame_done_cnt", fd_cnt, 1);
    if (n > 0) chk("frame_done_time", fd_cyc - obs_q[n-1].t, 1 + E + 40 * CLK);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    bit    hit;
    int    n;
    s = " Hello, world!   Spartan-3E LCD ";
    for (int i = 0; i < 32; i++) mem[i] = s[i];

    repeat (4) @(posedge clk);
    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_d", lcd_d, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_ce0", sf_ce0, 1);
    chk("rst_addr", char_addr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);

    release_rst();
    wait_frame();
    verify_frame();

    // reset while E is high on char 5's high nibble, random store afterwards
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(32, 126));
    repeat (3) @(posedge clk);
    release_rst();
    hit = 1'b0;
    for (int i = 0; i < 25000 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (obs_q.size() >= 25 && lcd_e) hit = 1'b1;
    end
    chk("mid_hit", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_e_drop", lcd_e, 0);
    chk("mid_addr", char_addr, 0);
    chk("mid_init_done", init_done, 0);
    repeat (3) @(posedge clk);
    release_rst();
    wait_frame();
    verify_frame();

    n = obs_q.size();
`ifdef LCD_REFRESH_EN
    for (int i = 0; i < R * CLK + 200 && obs_q.size() == n; i++) @(posedge clk);
    #2;
    chk("refresh_seen", obs_q.size() > n, 1);
    if (obs_q.size() > n) begin
      chk("refresh_gap", obs_q[n].t - fd_cyc, R * CLK + 2);
      chk("refresh_nib", {obs_q[n].rs, obs_q[n].nib}, 5'h08);
      chk("refresh_addr", obs_q[n].addr, 0);
    end
`else
    repeat (5000) @(posedge clk);
    #2;
    chk("idle_rises", obs_q.size(), n);
    chk("idle_e", lcd_e, 0);
    chk("idle_addr", char_addr, 31);
    chk("idle_init_done", init_done, 1);
`endif
    chk("end_rw", lcd_rw, 0);
    chk("end_ce0", sf_ce0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
